// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the IF (fetch) and MEM (load/store) stages.
// Latency: grant edge -> 1 issue cycle -> MEM_LAT wait cycles -> 1 ack cycle (MEM_LAT+2 per access).
// Backpressure: requesters hold req until their ack pulse; stall_if/stall_m hold the pipeline meanwhile.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              stall_if,
  // data port
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              stall_m,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t            state_q;
  logic              owner_dm_q;   // 1 = data port owns the current access
  logic              op_we_q;      // current access is a store (survives mem_we drop)
  logic [CNT_W-1:0]  cnt_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              if_ack_q;
  logic              dm_ack_q;

  logic              grant_dm_d;
  logic              grant_if_d;

  // Grant decision: DM wins from IDLE; in ACK the finishing owner is masked so the
  // other port gets the next slot, which gives alternation under sustained contention.
  always_comb begin
    grant_dm_d = 1'b0;
    grant_if_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        grant_dm_d = dm_req;
        grant_if_d = if_req & ~dm_req;
      end
      S_ACK: begin
        if (owner_dm_q) begin
          grant_if_d = if_req;
        end else begin
          grant_dm_d = dm_req;
        end
      end
      default: begin
        grant_dm_d = 1'b0;
        grant_if_d = 1'b0;
      end
    endcase
  end

  // Access sequencer: grant, single-cycle strobe, fixed-latency wait, capture and ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_dm_q  <= 1'b0;
      op_we_q     <= 1'b0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ACK: begin
          if_ack_q <= 1'b0;
          dm_ack_q <= 1'b0;
          if (grant_dm_d) begin
            owner_dm_q  <= 1'b1;
            op_we_q     <= dm_we;
            mem_en_q    <= 1'b1;
            mem_we_q    <= dm_we;
            mem_addr_q  <= dm_addr;
            mem_wdata_q <= dm_wdata;
            state_q     <= S_ISSUE;
          end else if (grant_if_d) begin
            owner_dm_q  <= 1'b0;
            op_we_q     <= 1'b0;
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
            state_q     <= S_ISSUE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ISSUE: begin
          // Strobe lasts exactly one cycle; address and write data stay put.
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          cnt_q    <= CNT_W'(MEM_LAT);
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q <= CNT_W'(1)) begin
            // Read data is valid in this cycle; stores leave dm_rdata alone.
            cnt_q <= '0;
            if (owner_dm_q) begin
              if (!op_we_q) begin
                dm_rdata_q <= mem_rdata;
              end
              dm_ack_q <= 1'b1;
            end else begin
              if_rdata_q <= mem_rdata;
              if_ack_q   <= 1'b1;
            end
            state_q <= S_ACK;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;

  // Stalls follow the request level until the ack pulse; forced low while in reset.
  assign stall_if = rst_n & if_req & ~if_ack_q;
  assign stall_m  = rst_n & dm_req & ~dm_ack_q;

endmodule
